result_collect: RTL

- Return-path counterpart to the operand demux. It gathers per-lane results from the MAC, DIV, EXP and LOG units and presents them on one 64-lane result bus.
- It records the mode of every issued operation in an in-order tag FIFO.
- Results are accepted only from the unit whose mode is at the FIFO head. This keeps results in issue order even when unit latencies differ.
- Output is a registered valid/ready stage with back-pressure to the units.

---
 rtl/result_collect.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/result_collect.sv
// result_collect: return-path collector for the MAC/DIV/EXP/LOG units.
//
// Every issued operation has its mode recorded in an in-order tag FIFO.
// Results are accepted only from the unit named at the FIFO head, so the
// results leave in issue order even when unit latencies differ. The output
// is one registered valid/ready stage, and its back-pressure reaches the units.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   issue, mode               launch an operation and give its mode (0 MAC, 1 DIV, 2 EXP, 3 LOG)
//   issue_ready               tag FIFO not full (decoded from the registered count)
//   res_*, vld_*              per-unit lane results and their valid
//   rdy_*                     per-unit result accepted (combinational)
//   oC, o_valid, o_mode       collected result, its valid, and its mode tag
//   o_ready                   downstream accepts oC
//   busy                      operations outstanding or result held
//   err                       sticky protocol error (dropped issue or stray result)

`ifndef MAC_BW
`define MAC_BW 16
`endif

module result_collect #(
    parameter int unsigned LANES = 64,
    parameter int unsigned BW    = `MAC_BW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       issue,
    input  logic [1:0]                 mode,
    output logic                       issue_ready,

    input  logic [LANES-1:0][BW-1:0]   res_mac,
    input  logic [LANES-1:0][BW-1:0]   res_div,
    input  logic [LANES-1:0][BW-1:0]   res_exp,
    input  logic [LANES-1:0][BW-1:0]   res_log,
    input  logic                       vld_mac,
    input  logic                       vld_div,
    input  logic                       vld_exp,
    input  logic                       vld_log,
    output logic                       rdy_mac,
    output logic                       rdy_div,
    output logic                       rdy_exp,
    output logic                       rdy_log,

    output logic [LANES-1:0][BW-1:0]   oC,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [1:0]                 o_mode,

    output logic                       busy,
    output logic                       err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] MODE_MAC = 2'd0;
    localparam logic [1:0] MODE_DIV = 2'd1;
    localparam logic [1:0] MODE_EXP = 2'd2;
    localparam logic [1:0] MODE_LOG = 2'd3;

    // State
    logic [1:0]                fifo_q [DEPTH];
    logic [1:0]                fifo_d [DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q,  count_d;
    logic [LANES-1:0][BW-1:0]  oc_q,     oc_d;
    logic                      o_valid_q, o_valid_d;
    logic [1:0]                o_mode_q, o_mode_d;
    logic                      err_q,    err_d;

    // Decode
    logic [1:0]                head;
    logic                      nonempty;
    logic                      full;
    logic                      out_free;
    logic [3:0]                vld_vec;
    logic [3:0]                head_oh;
    logic [3:0]                rdy_vec;
    logic                      accept;
    logic                      stray;
    logic                      push;
    logic                      drop;
    logic [LANES-1:0][BW-1:0]  head_res;

    // Head decode, unit handshake and stray/drop detection
    always_comb begin
        head     = fifo_q[rd_ptr_q];
        nonempty = (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        out_free = !o_valid_q || o_ready;
        vld_vec  = {vld_log, vld_exp, vld_div, vld_mac};

        head_oh       = '0;
        head_oh[head] = 1'b1;

        // Only the head unit is offered ready, never during reset.
        rdy_vec = '0;
        if (!rst && nonempty && out_free) begin
            rdy_vec = head_oh;
        end

        accept = |(vld_vec & rdy_vec);

        // Any valid from a non-head unit, or any valid with nothing issued.
        stray = nonempty ? |(vld_vec & ~head_oh) : |vld_vec;

        push = issue && !full;
        drop = issue && full;

        case (head)
            MODE_MAC: head_res = res_mac;
            MODE_DIV: head_res = res_div;
            MODE_EXP: head_res = res_exp;
            default:  head_res = res_log;
        endcase
    end

    // Next-state: tag FIFO, output stage, sticky error
    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        oc_d      = oc_q;
        o_valid_d = o_valid_q;
        o_mode_d  = o_mode_q;
        err_d     = err_q;

        if (push) begin
            fifo_d[wr_ptr_q] = mode;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (accept) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(accept);

        if (accept) begin
            oc_d      = head_res;
            o_mode_d  = head;
            o_valid_d = 1'b1;
        end else if (o_ready) begin
            // Drain clears valid only; oC keeps its last value.
            o_valid_d = 1'b0;
        end

        if (stray || drop) begin
            err_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= MODE_MAC;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            oc_q      <= '0;
            o_valid_q <= 1'b0;
            o_mode_q  <= MODE_MAC;
            err_q     <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            oc_q      <= oc_d;
            o_valid_q <= o_valid_d;
            o_mode_q  <= o_mode_d;
            err_q     <= err_d;
        end
    end

    assign issue_ready = !full;
    assign rdy_mac     = rdy_vec[0];
    assign rdy_div     = rdy_vec[1];
    assign rdy_exp     = rdy_vec[2];
    assign rdy_log     = rdy_vec[3];
    assign oC          = oc_q;
    assign o_valid     = o_valid_q;
    assign o_mode      = o_mode_q;
    assign err         = err_q;
    assign busy        = nonempty || o_valid_q;

endmodule
